// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Purpose  : Oversampled UART receiver with configurable frame format,
//             show-ahead receive FIFO and sticky error flags.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          pin,
    output logic [7:0]                    dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          framing_err,
    output logic                          parity_err,
    output logic                          overrun_err,
    input  logic                          err_clear,
    output logic                          busy
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int IW   = $clog2(DATA_BITS);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;

    localparam logic [CW-1:0]   c_HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]   c_FULL_M1   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   c_BAUD_ONE  = CW'(1);
    localparam logic [IW-1:0]   c_LAST_BIT  = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0]   c_BIT_ONE   = IW'(1);
    localparam logic [AW-1:0]   c_PTR_ONE   = AW'(1);
    localparam logic [CNTW-1:0] c_CNT_ONE   = CNTW'(1);
    localparam logic [CNTW-1:0] c_DEPTH     = CNTW'(FIFO_DEPTH);
    localparam logic            c_LAST_STOP = (STOP_BITS == 2);
    localparam logic            c_ODD       = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 r_state;
    logic                   r_sync1;
    logic                   r_sync2;
    logic [CW-1:0]          r_baud;
    logic [IW-1:0]          r_bit;
    logic                   r_stop_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_bad_parity;
    logic                   r_bad_frame;

    logic                   w_rx;
    logic                   w_tick;
    logic                   w_parity_bad;
    logic                   w_frame_done;
    logic                   w_frame_bad;
    logic                   w_push_req;
    logic                   w_set_fe;
    logic                   w_set_pe;
    logic                   w_set_oe;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_push;

    logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wr;
    logic [AW-1:0]          r_rd;
    logic [CNTW-1:0]        r_count;
    logic                   r_fe;
    logic                   r_pe;
    logic                   r_oe;

    assign w_rx         = r_sync2;
    assign w_tick       = (r_baud == '0);
    assign w_parity_bad = c_ODD ? ~(^r_shift ^ w_rx) : (^r_shift ^ w_rx);

    // The final stop sample is folded in here so the verdict lands on the same edge.
    assign w_frame_done = (r_state == S_STOP) && w_tick && (r_stop_idx == c_LAST_STOP);
    assign w_frame_bad  = r_bad_frame | ~w_rx;
    assign w_push_req   = w_frame_done && !w_frame_bad && !r_bad_parity;
    assign w_set_fe     = w_frame_done && w_frame_bad;
    assign w_set_pe     = w_frame_done && !w_frame_bad && r_bad_parity;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= pin;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_baud       <= '0;
            r_bit        <= '0;
            r_stop_idx   <= 1'b0;
            r_shift      <= '0;
            r_bad_parity <= 1'b0;
            r_bad_frame  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_rx) begin
                        r_state <= S_START;
                        r_baud  <= c_HALF_M1;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (!w_rx) begin
                            r_state      <= S_DATA;
                            r_bit        <= '0;
                            r_baud       <= c_FULL_M1;
                            r_bad_parity <= 1'b0;
                            r_bad_frame  <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud - c_BAUD_ONE;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_shift[r_bit] <= w_rx;
                        r_baud         <= c_FULL_M1;
                        if (r_bit == c_LAST_BIT) begin
                            r_state    <= (PARITY != 0) ? S_PARITY : S_STOP;
                            r_stop_idx <= 1'b0;
                        end else begin
                            r_bit <= r_bit + c_BIT_ONE;
                        end
                    end else begin
                        r_baud <= r_baud - c_BAUD_ONE;
                    end
                end
                S_PARITY: begin
                    if (w_tick) begin
                        r_bad_parity <= w_parity_bad;
                        r_state      <= S_STOP;
                        r_stop_idx   <= 1'b0;
                        r_baud       <= c_FULL_M1;
                    end else begin
                        r_baud <= r_baud - c_BAUD_ONE;
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        if (!w_rx) begin
                            r_bad_frame <= 1'b1;
                        end
                        r_baud <= c_FULL_M1;
                        if (r_stop_idx == c_LAST_STOP) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud - c_BAUD_ONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_DEPTH);
    assign w_pop    = !w_empty && dout_ready;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign w_push   = w_push_req && (!w_full || w_pop);
    assign w_set_oe = w_push_req && w_full && !w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd <= r_rd + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= r_shift;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fe <= 1'b0;
            r_pe <= 1'b0;
            r_oe <= 1'b0;
        end else begin
            r_fe <= w_set_fe | (r_fe & ~err_clear);
            r_pe <= w_set_pe | (r_pe & ~err_clear);
            r_oe <= w_set_oe | (r_oe & ~err_clear);
        end
    end

    always_comb begin
        dout = '0;
        if (!w_empty) begin
            dout[DATA_BITS-1:0] = r_mem[r_rd];
        end
    end

    assign dout_valid  = !w_empty;
    assign count       = r_count;
    assign framing_err = r_fe;
    assign parity_err  = r_pe;
    assign overrun_err = r_oe;
    assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// Bench for uart_rx_fifo: three instances (8N1, 8E1, 5N2) driven with serial
// frames and checked against a queue-based model of the receive path.
module tb_uart_rx_fifo;

    localparam int C_BIT = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       pin_a = 1'b1, rdy_a = 1'b0, clr_a = 1'b0;
    logic [7:0] dout_a;
    logic [2:0] cnt_a;
    logic       dv_a, fe_a, pe_a, oe_a, busy_a;

    logic       pin_p = 1'b1, rdy_p = 1'b0, clr_p = 1'b0;
    logic [7:0] dout_p;
    logic [2:0] cnt_p;
    logic       dv_p, fe_p, pe_p, oe_p, busy_p;

    logic       pin_d = 1'b1, rdy_d = 1'b0, clr_d = 1'b0;
    logic [7:0] dout_d;
    logic [2:0] cnt_d;
    logic       dv_d, fe_d, pe_d, oe_d, busy_d;

    uart_rx_fifo u_dut (
        .clk(clk), .reset(reset), .pin(pin_a), .dout(dout_a), .dout_valid(dv_a),
        .dout_ready(rdy_a), .count(cnt_a), .framing_err(fe_a), .parity_err(pe_a),
        .overrun_err(oe_a), .err_clear(clr_a), .busy(busy_a)
    );

    uart_rx_fifo #(.PARITY(1)) u_par (
        .clk(clk), .reset(reset), .pin(pin_p), .dout(dout_p), .dout_valid(dv_p),
        .dout_ready(rdy_p), .count(cnt_p), .framing_err(fe_p), .parity_err(pe_p),
        .overrun_err(oe_p), .err_clear(clr_p), .busy(busy_p)
    );

    uart_rx_fifo #(.DATA_BITS(5), .STOP_BITS(2)) u_d5 (
        .clk(clk), .reset(reset), .pin(pin_d), .dout(dout_d), .dout_valid(dv_d),
        .dout_ready(rdy_d), .count(cnt_d), .framing_err(fe_d), .parity_err(pe_d),
        .overrun_err(oe_d), .err_clear(clr_d), .busy(busy_d)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model for the 8N1 instance.
    logic [7:0] q_a[$];
    logic       fe_m = 1'b0, oe_m = 1'b0;

    int   cyc = 0;
    int   rise_a = 0;
    int   t_start = 0;
    logic dv_a_q = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        dv_a_q <= dv_a;
        if (dv_a && !dv_a_q) rise_a <= cyc;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives n bits LSB first, each held for one bit period.
    task automatic send_bits(input int sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel == 0 && i == 0) t_start = cyc;
            case (sel)
                0:       pin_a = bits[i];
                1:       pin_p = bits[i];
                default: pin_d = bits[i];
            endcase
            tick(C_BIT);
        end
    endtask

    task automatic model_frame(input logic [7:0] d, input logic stop_ok);
        if (!stop_ok)              fe_m = 1'b1;
        else if (q_a.size() == 4)  oe_m = 1'b1;
        else                       q_a.push_back(d);
    endtask

    task automatic pop_a(input string tag);
        @(negedge clk);
        if (q_a.size() != 0) begin
            n_cmp++;
            if (dout_a !== q_a[0] || dv_a !== 1'b1) begin
                n_err++;
                $display("FAIL %s_pop: got dout=%h valid=%b want dout=%h valid=1", tag, dout_a, dv_a, q_a[0]);
            end
        end else begin
            n_cmp++;
            if (dv_a !== 1'b0) begin
                n_err++;
                $display("FAIL %s_pop_empty: got valid=%b want 0", tag, dv_a);
            end
        end
        @(posedge clk); #1 rdy_a = 1'b1;
        @(posedge clk); #1 rdy_a = 1'b0;
        if (q_a.size() != 0) void'(q_a.pop_front());
    endtask

    task automatic clear_a();
        clr_a = 1'b1; tick(1); clr_a = 1'b0;
        fe_m = 1'b0; oe_m = 1'b0;
    endtask

    task automatic check_state_a(input string tag);
        @(negedge clk);
        n_cmp++;
        if (cnt_a !== 3'(q_a.size()) || fe_a !== fe_m || oe_a !== oe_m || pe_a !== 1'b0) begin
            n_err++;
            $display("FAIL %s_state: got cnt=%0d fe=%b oe=%b pe=%b want cnt=%0d fe=%b oe=%b pe=0",
                     tag, cnt_a, fe_a, oe_a, pe_a, q_a.size(), fe_m, oe_m);
        end
        tick(1);
    endtask

    task automatic test_reset();
        tick(3);
        @(negedge clk);
        n_cmp++;
        if ({dout_a, dv_a, cnt_a, fe_a, pe_a, oe_a, busy_a} !== 15'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got dout=%h v=%b cnt=%0d fe=%b pe=%b oe=%b busy=%b want all 0",
                     dout_a, dv_a, cnt_a, fe_a, pe_a, oe_a, busy_a);
        end
        @(posedge clk); #1 reset = 1'b0;
        tick(5);
        @(negedge clk);
        n_cmp++;
        if (busy_a !== 1'b0 || busy_p !== 1'b0 || busy_d !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: got busy=%b%b%b want 000", busy_a, busy_p, busy_d);
        end
        tick(1);
    endtask

    task automatic test_basic();
        send_bits(0, {6'h3F, 1'b1, 8'hA5, 1'b0}, 10);
        model_frame(8'hA5, 1'b1);
        tick(4);
        @(negedge clk);
        n_cmp++;
        if (dout_a !== 8'hA5 || dv_a !== 1'b1) begin
            n_err++;
            $display("FAIL basic_data: got dout=%h valid=%b want a5 1", dout_a, dv_a);
        end
        n_cmp++;
        if (rise_a - t_start < 154 || rise_a - t_start > 156) begin
            n_err++;
            $display("FAIL basic_latency: got %0d cycles want 154..156", rise_a - t_start);
        end
        tick(1);
        check_state_a("basic");
        pop_a("basic");
        check_state_a("basic_after_pop");
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 5; i++) begin
            send_bits(0, {6'h3F, 1'b1, 8'(i), 1'b0}, 10);
            model_frame(8'(i), 1'b1);
        end
        tick(4);
        check_state_a("b2b_full");
        for (int i = 0; i < 5; i++) pop_a("b2b");
        clear_a();
        check_state_a("b2b_cleared");
    endtask

    task automatic test_framing();
        send_bits(0, {6'h3F, 1'b0, 8'h3C, 1'b0}, 10);
        pin_a = 1'b1;
        model_frame(8'h3C, 1'b0);
        tick(24);
        check_state_a("framing_set");
        clear_a();
        check_state_a("framing_cleared");
        send_bits(0, {6'h3F, 1'b1, 8'h3C, 1'b0}, 10);
        model_frame(8'h3C, 1'b1);
        tick(4);
        check_state_a("framing_next");
        pop_a("framing_next");
    endtask

    task automatic test_glitch();
        logic saw_busy = 1'b0;
        pin_a = 1'b0; tick(6); pin_a = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy_a) saw_busy = 1'b1;
        end
        n_cmp++;
        if (saw_busy !== 1'b1 || busy_a !== 1'b0) begin
            n_err++;
            $display("FAIL glitch_busy: got pulse=%b final=%b want 1 0", saw_busy, busy_a);
        end
        tick(1);
        check_state_a("glitch");
    endtask

    task automatic test_random();
        for (int f = 0; f < 14; f++) begin
            logic [7:0] d = 8'($urandom);
            logic ok = ($urandom_range(4) != 0);
            send_bits(0, {6'h3F, ok, d, 1'b0}, 10);
            pin_a = 1'b1;
            model_frame(d, ok);
            tick(24);
            check_state_a("random");
            for (int p = $urandom_range(2); p > 0; p--) pop_a("random");
        end
        while (q_a.size() != 0) pop_a("random_drain");
        clear_a();
        check_state_a("random_end");
    endtask

    task automatic test_reset_mid();
        send_bits(0, {6'h3F, 1'b0, 8'h11, 1'b0}, 10);
        pin_a = 1'b1;
        model_frame(8'h11, 1'b0);
        tick(24);
        send_bits(0, {6'h3F, 1'b1, 8'h22, 1'b0}, 10);
        model_frame(8'h22, 1'b1);
        send_bits(0, {6'h3F, 1'b1, 8'h33, 1'b0}, 10);
        model_frame(8'h33, 1'b1);
        tick(4);
        check_state_a("pre_reset");
        send_bits(0, 16'hFFFE, 5);
        reset = 1'b1;
        pin_a = 1'b1;
        q_a.delete(); fe_m = 1'b0; oe_m = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cnt_a !== 3'd0 || fe_a !== 1'b0 || busy_a !== 1'b0 || dv_a !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: got cnt=%0d fe=%b busy=%b valid=%b want 0 0 0 0", cnt_a, fe_a, busy_a, dv_a);
        end
        tick(2);
        reset = 1'b0;
        tick(170);
        check_state_a("reset_no_partial");
        send_bits(0, {6'h3F, 1'b1, 8'h5A, 1'b0}, 10);
        model_frame(8'h5A, 1'b1);
        tick(4);
        check_state_a("reset_next");
        pop_a("reset_next");
    endtask

    task automatic test_parity();
        int exp_cnt = 0;
        logic exp_pe = 1'b0;
        logic [7:0] exp_head = 8'h00;
        for (int f = 0; f < 6; f++) begin
            logic [7:0] d = (f < 2) ? 8'h07 : 8'($urandom);
            logic pb = (f == 0) ? 1'b1 : (f == 1) ? 1'b0 : 1'($urandom);
            send_bits(1, {5'h1F, 1'b1, pb, d, 1'b0}, 11);
            pin_p = 1'b1;
            // Even parity: total count of ones over data and parity bit is even.
            if ((($countones(d) + pb) % 2) == 0) begin
                exp_cnt++;
                exp_head = d;
            end else begin
                exp_pe = 1'b1;
            end
            tick(6);
            @(negedge clk);
            n_cmp++;
            if (cnt_p !== 3'(exp_cnt) || pe_p !== exp_pe || fe_p !== 1'b0) begin
                n_err++;
                $display("FAIL parity_frame%0d: got cnt=%0d pe=%b fe=%b want cnt=%0d pe=%b fe=0",
                         f, cnt_p, pe_p, fe_p, exp_cnt, exp_pe);
            end
            if (exp_cnt != 0) begin
                n_cmp++;
                if (dout_p !== exp_head) begin
                    n_err++;
                    $display("FAIL parity_data%0d: got %h want %h", f, dout_p, exp_head);
                end
            end
            tick(1);
            rdy_p = 1'b1; tick(1); rdy_p = 1'b0;
            exp_cnt = 0;
        end
    endtask

    task automatic test_d5();
        send_bits(2, {8'hFF, 2'b11, 5'h15, 1'b0}, 8);
        tick(4);
        @(negedge clk);
        n_cmp++;
        if (dout_d !== 8'h15 || cnt_d !== 3'd1 || fe_d !== 1'b0) begin
            n_err++;
            $display("FAIL d5_data: got dout=%h cnt=%0d fe=%b want 15 1 0", dout_d, cnt_d, fe_d);
        end
        tick(1);
        send_bits(2, {8'hFF, 2'b01, 5'h1F, 1'b0}, 8);
        pin_d = 1'b1;
        tick(24);
        @(negedge clk);
        n_cmp++;
        if (fe_d !== 1'b1 || cnt_d !== 3'd1 || dout_d !== 8'h15) begin
            n_err++;
            $display("FAIL d5_stop2: got fe=%b cnt=%0d dout=%h want 1 1 15", fe_d, cnt_d, dout_d);
        end
        tick(1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_framing();
        test_glitch();
        test_random();
        test_reset_mid();
        test_parity();
        test_d5();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver: oversampled serial input, configurable frame format, receive FIFO with valid/ready read port and sticky error flags. Replaces the one-bit-per-clock receiver in the SD host controller's debug/command UART path. Sits between the board RX pin and the host-side command parser.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit; must be >=4. Counter width is clog2(CLKS_PER_BIT).
DATA_BITS, 8, data bits per frame; legal range 5..8.
PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop bits checked; legal values 1 or 2.
FIFO_DEPTH, 4, receive FIFO entries; power of two, >=2.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
pin  in  1  asynchronous serial input; idles high
dout  out  8  FIFO head byte; data in bits [DATA_BITS-1:0], upper bits zero
dout_valid  out  1  FIFO non-empty
dout_ready  in  1  consumer pops the head when dout_valid && dout_ready
count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
framing_err  out  1  sticky: a stop bit was sampled low
parity_err  out  1  sticky: parity mismatch
overrun_err  out  1  sticky: good frame arrived while FIFO full
err_clear  in  1  single-cycle pulse; clears all three sticky flags
busy  out  1  receiver is not in IDLE

Behaviour:
- Reset: all outputs 0. FIFO empty, FSM in IDLE, synchroniser flops set to 1, counters 0.
- pin passes through a 2-flop synchroniser (rx_s) before all logic. The synchroniser adds 2 cycles of latency.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: when rx_s==0, go to START and load the baud counter.
- START: wait CLKS_PER_BIT/2 cycles, then sample rx_s.
  - If rx_s==0: go to DATA, bit index = 0.
  - If rx_s==1: false start; return to IDLE. No flags, no push.
- DATA: sample every CLKS_PER_BIT cycles at mid-bit, LSB first, into shift register bit[index].
  - After bit DATA_BITS-1, go to PARITY if PARITY!=0, else STOP.
- PARITY: sample one bit at mid-bit.
  - Even mode: XOR of data bits plus parity bit must be 0.
  - Odd mode: that XOR must be 1.
  - On mismatch, set the frame-local bad_parity flag.
- STOP: sample STOP_BITS bits at mid-bit.
  - Any stop sample == 0 sets bad_frame.
  - After the final stop sample, the frame is complete; return to IDLE on the same edge.
- On frame complete:
  - bad_frame sets framing_err and the byte is discarded.
  - Otherwise bad_parity sets parity_err and the byte is discarded.
  - Otherwise the byte is a push request on that edge.
- The receiver returns to IDLE mid-stop-bit. It re-arms immediately, so a back-to-back start edge is caught.
- busy = (state != IDLE).
- FIFO: show-ahead. dout and dout_valid reflect the head combinationally from registers. A pushed byte appears with dout_valid=1 on the cycle after the push edge.
- Pop occurs when dout_valid && dout_ready. Pop with empty FIFO is ignored.
- Push when full without a simultaneous pop: byte dropped, overrun_err set, FIFO unchanged.
- Push and pop in the same cycle:
  - When full: both accepted, count unchanged.
  - When empty: push accepted, pop ignored, because dout_valid was 0.
- Pointers wrap modulo FIFO_DEPTH. count range is 0..FIFO_DEPTH.
- Sticky flags: a set event and err_clear in the same cycle leaves the flag set (set wins).
- Reset mid-frame aborts reception, empties the FIFO and clears flags. No partial byte is ever pushed.
- Total latency, start-bit falling edge on pin to dout_valid: 2 + CLKS_PER_BIT/2 + (DATA_BITS + P + STOP_BITS)*CLKS_PER_BIT + 1 cycles ±1, where P = 1 if PARITY!=0, else 0.

Test Plan:
- Defaults (CLKS_PER_BIT=16, 8N1). Send 0xA5 with dout_ready=0 -> dout=0xA5, dout_valid=1, count=1, no error flags. Assert dout_ready for 1 cycle -> dout_valid=0, count=0.
- Defaults, dout_ready=0. Send 0x01, 0x02, 0x03, 0x04, 0x05 back-to-back -> count=4, overrun_err=1. Pops return 0x01..0x04 in order; 0x05 is lost.
- Stop bit driven low while sending 0x3C -> framing_err=1, count unchanged. Pulse err_clear -> framing_err=0. Next frame 0x3C is received correctly.
- PARITY=1 (even). Send 0x07 with parity bit 1 -> accepted. Send 0x07 with parity bit 0 -> parity_err=1, no push.
- 6-cycle low glitch on pin while IDLE (CLKS_PER_BIT=16) -> busy pulses, returns to IDLE, no push, no flags.
- Assert reset halfway through the data bits of 0xFF with 2 bytes already queued -> count=0, all flags 0, busy=0. The following frame 0x5A is received correctly.
- DATA_BITS=5, STOP_BITS=2. Send 0x15 -> dout=0x15 with upper bits zero. Send a frame with only the second stop bit low -> framing_err=1.
